pulse_run_sequencer: RTL and testbench
======================================

Name: pulse_run_sequencer

Overview:
- Run controller for the pulse-measurement stream block.
- Gates that block via its active-low reset and counts completed measurement periods, detected as a case_id transition from 4 to 0.
- Stops after a programmed number of periods, or aborts early on overload, on software stop, or on watchdog expiry.
- Sits between the PS config/status registers and the measurement core. It is the only driver of that core's reset.

Parameters:
- CNTR_WIDTH, 32, width of the period-count target and of the completed-period counter.
- HOLDOFF_WIDTH, 16, width of the arm-delay counter.
- WDOG_CYCLES, 1048576, watchdog limit in aclk cycles. Used only when the optional feature is compiled in.

Ports:
- aclk  in  1  system clock; all logic is on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cfg_data  in  CNTR_WIDTH+HOLDOFF_WIDTH+8  configuration word:
  - [CNTR_WIDTH-1:0] pulse_count
  - next HOLDOFF_WIDTH bits: holdoff
  - bit C = CNTR_WIDTH+HOLDOFF_WIDTH: start
  - bit C+1: abort_on_overload
  - remaining bits: reserved, ignored.
- case_id  in  3  state of the measurement core.
- overload  in  1  overload flag from the measurement core.
- meas_aresetn  out  1  reset to the measurement core; registered.
- busy  out  1  high in ARM or RUN.
- done  out  1  high in DONE.
- aborted  out  1  sticky; set by any early termination.
- pulse_cntr  out  CNTR_WIDTH  number of completed periods.
- sts_data  out  32  packed status: {state[2:0], aborted, done, busy, ovl_seen, timeout, pulse_cntr[23:0]}.

Behaviour:
- Reset (aresetn low, asynchronous) forces the following; all outputs are registered:
  - state=IDLE
  - meas_aresetn=0, busy=0, done=0, aborted=0, ovl_seen=0, timeout=0
  - pulse_cntr=0, start_d=0, case_d=0
- Edge and transition detection:
  - start_rise = start & ~start_d.
  - complete = (case_d==4) & (case_id==0), where case_d is case_id registered once per cycle.
- State encoding: IDLE=0, ARM=1, RUN=2, DONE=3.
- IDLE:
  - meas_aresetn=0.
  - On start_rise, clear pulse_cntr, aborted, ovl_seen and timeout, then:
    - pulse_count==0 → go to DONE; core is never released.
    - otherwise → go to ARM and load the holdoff counter with holdoff.
- ARM:
  - meas_aresetn=0; decrement the holdoff counter each cycle.
  - When the counter equals 0 → go to RUN. holdoff=0 gives exactly 1 cycle in ARM.
  - start low → go to IDLE with aborted=1.
- RUN:
  - meas_aresetn=1 from the first RUN cycle.
  - On complete, pulse_cntr increments and overload is sampled in that same cycle; ovl_seen |= overload.
  - Exit priority, highest first:
    1. start low → go to DONE with aborted=1.
    2. complete & overload & abort_on_overload → go to DONE with aborted=1; pulse_cntr still counts this period.
    3. complete & (pulse_cntr+1 == pulse_count) → go to DONE.
  - overload is ignored outside complete cycles: the core's flag is stale between periods.
- DONE:
  - meas_aresetn=0, done=1; pulse_cntr and flags hold.
  - start low → go to IDLE; done clears, aborted holds until the next start_rise.
- Other rules:
  - start_rise seen in ARM, RUN or DONE is ignored; a new run requires start to go low first.
  - cfg_data fields are sampled live. pulse_count is compared every complete cycle; software must not change it mid-run.
  - pulse_cntr saturates at all-ones and does not wrap.
  - Asynchronous reset mid-RUN drops meas_aresetn immediately.

Optional Feature:
- Macro: PULSE_RUN_SEQUENCER_WATCHDOG_EN.
- When defined:
  - A watchdog counter clears on entry to RUN and on every complete cycle, and increments on every other RUN cycle.
  - When it reaches WDOG_CYCLES-1 → go to DONE with aborted=1 and timeout=1.
  - This exit has the lowest priority, below all three RUN exits.
- When undefined: no counter is built and timeout is constant 0.

Test Plan:
- pulse_count=3, holdoff=5, start rises, three 0..4→0 case_id cycles, overload=0 → exactly 5 ARM cycles, meas_aresetn=1 in RUN, DONE after 3rd complete, pulse_cntr=3, aborted=0, done=1.
- pulse_count=0, start rises → DONE next cycle, meas_aresetn never 1, pulse_cntr=0.
- pulse_count=10, abort_on_overload=1, overload=1 on 2nd complete only → DONE, pulse_cntr=2, aborted=1, ovl_seen=1.
  - Repeat with abort_on_overload=0 → runs to 10 with ovl_seen=1, aborted=0.
- start deasserted mid-RUN after 4 periods → DONE with pulse_cntr=4, aborted=1. Deassert start during ARM → IDLE, aborted=1.
- aresetn pulsed low mid-RUN (not aligned to aclk) → all outputs 0 immediately. Next start_rise begins a clean run.
- Watchdog build with WDOG_CYCLES=64: case_id stuck at 2 in RUN → DONE 64 cycles after RUN entry, timeout=1, aborted=1. Non-watchdog build: stays in RUN, timeout=0.

Source files
------------

// File: rtl/pulse_run_sequencer.sv
// Run controller for the pulse-measurement core: gates its reset and counts completed periods.
// Optional watchdog abort is compiled in with PULSE_RUN_SEQUENCER_WATCHDOG_EN.
module pulse_run_sequencer #(
    parameter int unsigned CNTR_WIDTH    = 32,
    parameter int unsigned HOLDOFF_WIDTH = 16,
    parameter int unsigned WDOG_CYCLES   = 1048576
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [CNTR_WIDTH+HOLDOFF_WIDTH+7:0] cfg_data,
    input  logic [2:0]                          case_id,
    input  logic                                overload,
    output logic                                meas_aresetn,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted,
    output logic [CNTR_WIDTH-1:0]               pulse_cntr,
    output logic [31:0]                         sts_data
);

    localparam int unsigned StartBit = CNTR_WIDTH + HOLDOFF_WIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

    logic [CNTR_WIDTH-1:0]    pulse_count;
    logic [HOLDOFF_WIDTH-1:0] holdoff;
    logic                     start;
    logic                     abort_on_ovl;
    logic                     unused_cfg;

    assign pulse_count  = cfg_data[CNTR_WIDTH-1:0];
    assign holdoff      = cfg_data[StartBit-1:CNTR_WIDTH];
    assign start        = cfg_data[StartBit];
    assign abort_on_ovl = cfg_data[StartBit+1];
    assign unused_cfg   = ^cfg_data[StartBit+7:StartBit+2];

    state_e                   state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
    logic [CNTR_WIDTH-1:0]    cntr_q, cntr_d;
    logic                     start_q, aborted_q, aborted_d, ovl_q, ovl_d, timeout_q, timeout_d;
    logic                     meas_q, meas_d, busy_q, busy_d, done_q, done_d;
    logic [2:0]               case_q;
    logic                     start_rise, complete, last_period, wdog_expired;
    logic [CNTR_WIDTH:0]      cntr_inc;

    assign start_rise  = start & ~start_q;
    assign complete    = (case_q == 3'd4) && (case_id == 3'd0);
    assign cntr_inc    = {1'b0, cntr_q} + {{CNTR_WIDTH{1'b0}}, 1'b1};
    // Extra bit keeps a saturated counter from ever matching the target.
    assign last_period = (cntr_inc == {1'b0, pulse_count});

`ifdef PULSE_RUN_SEQUENCER_WATCHDOG_EN
    localparam int unsigned WdogWidth = $clog2(WDOG_CYCLES) + 1;

    logic [WdogWidth-1:0] wdog_q, wdog_d;

    assign wdog_expired = (wdog_q == WdogWidth'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_d = '0;
        if (state_q == StRun && !complete) begin
            wdog_d = wdog_q + WdogWidth'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;

    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cntr_d    = cntr_q;
        aborted_d = aborted_q;
        ovl_d     = ovl_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    cntr_d    = '0;
                    aborted_d = 1'b0;
                    ovl_d     = 1'b0;
                    timeout_d = 1'b0;
                    if (pulse_count == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StArm;
                        hold_d  = holdoff;
                    end
                end
            end
            StArm: begin
                if (!start) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else begin
                    // Leave when the decremented count reaches zero; holdoff of 0 still gives one cycle.
                    hold_d = hold_q - HOLDOFF_WIDTH'(1);
                    if (hold_q <= HOLDOFF_WIDTH'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (complete) begin
                    if (cntr_q != '1) begin
                        cntr_d = cntr_inc[CNTR_WIDTH-1:0];
                    end
                    ovl_d = ovl_q | overload;
                end
                if (!start) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (complete && overload && abort_on_ovl) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (complete && last_period) begin
                    state_d = StDone;
                end else if (wdog_expired) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        meas_d = (state_d == StRun);
        busy_d = (state_d == StArm) || (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            cntr_q    <= '0;
            start_q   <= 1'b0;
            case_q    <= 3'd0;
            aborted_q <= 1'b0;
            ovl_q     <= 1'b0;
            timeout_q <= 1'b0;
            meas_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cntr_q    <= cntr_d;
            start_q   <= start;
            case_q    <= case_id;
            aborted_q <= aborted_d;
            ovl_q     <= ovl_d;
            timeout_q <= timeout_d;
            meas_q    <= meas_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign meas_aresetn = meas_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign pulse_cntr   = cntr_q;
    assign sts_data     = {1'b0, state_q, aborted_q, done_q, busy_q, ovl_q, timeout_q, cntr_q[23:0]};

endmodule

// File: tb/tb_pulse_run_sequencer.sv
// Table-driven bench for pulse_run_sequencer plus directed reset and watchdog sequences.
module tb_pulse_run_sequencer;

    localparam logic [2:0] SI = 3'd0, SA = 3'd1, SR = 3'd2, SD = 3'd3;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [55:0] cfg_data;
    logic [2:0]  case_id;
    logic        overload;
    logic        meas_aresetn, busy, done, aborted;
    logic [31:0] pulse_cntr;
    logic [31:0] sts_data;

    pulse_run_sequencer #(
        .CNTR_WIDTH   (32),
        .HOLDOFF_WIDTH(16),
        .WDOG_CYCLES  (64)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cfg_data    (cfg_data),
        .case_id     (case_id),
        .overload    (overload),
        .meas_aresetn(meas_aresetn),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .pulse_cntr  (pulse_cntr),
        .sts_data    (sts_data)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        start;
        logic [31:0] pc;
        logic [15:0] ho;
        logic        aoo;
        logic [2:0]  cid;
        logic        ovl;
        logic [2:0]  st;
        logic        ab;
        logic        ovs;
        logic [31:0] cnt;
    } vec_t;

    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_pc;
    logic [15:0] cur_ho;
    logic        cur_aoo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [2:0] cid, input logic ovl, input logic [2:0] st,
                       input logic ab, input logic ovs, input logic [31:0] cnt);
        vec_t v;
        v.start = s;   v.pc = cur_pc; v.ho = cur_ho; v.aoo = cur_aoo;
        v.cid   = cid; v.ovl = ovl;   v.st = st;     v.ab = ab;
        v.ovs   = ovs; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // One 1,2,3,4,0 case_id period while in RUN with start held high.
    task automatic period(input logic ovl_c, input logic ovl_mid, input logic [2:0] st_end,
                          input logic ab_end, input logic ovs_before, input logic ovs_end,
                          input logic [31:0] cnt_before);
        for (int c = 1; c <= 4; c++) begin
            add(1'b1, 3'(c), ovl_mid, SR, 1'b0, ovs_before, cnt_before);
        end
        add(1'b1, 3'd0, ovl_c, st_end, ab_end, ovs_end, cnt_before + 32'd1);
    endtask

    task automatic drive(input logic s, input logic [31:0] pc, input logic [15:0] ho,
                         input logic aoo, input logic [2:0] cid, input logic ovl);
        cfg_data = {6'd0, aoo, s, ho, pc};
        case_id  = cid;
        overload = ovl;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [63:0] expect_vec(input logic [2:0] st, input logic ab, input logic ovs,
                                               input logic to, input logic [31:0] cnt);
        return {23'd0, st, st == SR, (st == SA) || (st == SR), st == SD, ab, ovs, to, cnt};
    endfunction

    function automatic logic [63:0] actual_vec();
        return {23'd0, sts_data[31:29], meas_aresetn, busy, done, aborted, sts_data[25],
                sts_data[24], pulse_cntr};
    endfunction

    initial begin
        aresetn = 1'b0;
        drive(1'b0, 32'd0, 16'd0, 1'b0, 3'd0, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        check("reset_state", actual_vec(), expect_vec(SI, 1'b0, 1'b0, 1'b0, 32'd0));
        check("reset_sts", {32'd0, sts_data}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Normal run: 3 periods after 5 ARM cycles.
        cur_pc = 32'd3; cur_ho = 16'd5; cur_aoo = 1'b0;
        for (int i = 0; i < 5; i++) add(1'b1, 3'd0, 1'b0, SA, 1'b0, 1'b0, 32'd0);
        add(1'b1, 3'd0, 1'b0, SR, 1'b0, 1'b0, 32'd0);
        period(1'b0, 1'b0, SR, 1'b0, 1'b0, 1'b0, 32'd0);
        period(1'b0, 1'b0, SR, 1'b0, 1'b0, 1'b0, 32'd1);
        period(1'b0, 1'b0, SD, 1'b0, 1'b0, 1'b0, 32'd2);
        add(1'b1, 3'd0, 1'b0, SD, 1'b0, 1'b0, 32'd3);
        add(1'b0, 3'd0, 1'b0, SI, 1'b0, 1'b0, 32'd3);

        // Zero target: straight to DONE, core never released.
        cur_pc = 32'd0;
        add(1'b1, 3'd0, 1'b0, SD, 1'b0, 1'b0, 32'd0);
        add(1'b1, 3'd0, 1'b0, SD, 1'b0, 1'b0, 32'd0);
        add(1'b0, 3'd0, 1'b0, SI, 1'b0, 1'b0, 32'd0);

        // Overload abort on 2nd complete; mid-period overload must be ignored.
        cur_pc = 32'd10; cur_ho = 16'd0; cur_aoo = 1'b1;
        add(1'b1, 3'd0, 1'b0, SA, 1'b0, 1'b0, 32'd0);
        add(1'b1, 3'd0, 1'b0, SR, 1'b0, 1'b0, 32'd0);
        period(1'b0, 1'b1, SR, 1'b0, 1'b0, 1'b0, 32'd0);
        period(1'b1, 1'b0, SD, 1'b1, 1'b0, 1'b1, 32'd1);
        add(1'b0, 3'd0, 1'b0, SI, 1'b1, 1'b1, 32'd2);

        // Same overload pattern without abort: runs to 10.
        cur_aoo = 1'b0;
        add(1'b1, 3'd0, 1'b0, SA, 1'b0, 1'b0, 32'd0);
        add(1'b1, 3'd0, 1'b0, SR, 1'b0, 1'b0, 32'd0);
        period(1'b0, 1'b1, SR, 1'b0, 1'b0, 1'b0, 32'd0);
        period(1'b1, 1'b0, SR, 1'b0, 1'b0, 1'b1, 32'd1);
        for (int k = 2; k <= 8; k++) period(1'b0, 1'b0, SR, 1'b0, 1'b1, 1'b1, 32'(k));
        period(1'b0, 1'b0, SD, 1'b0, 1'b1, 1'b1, 32'd9);
        add(1'b0, 3'd0, 1'b0, SI, 1'b0, 1'b1, 32'd10);

        // Software stop after 4 periods.
        add(1'b1, 3'd0, 1'b0, SA, 1'b0, 1'b0, 32'd0);
        add(1'b1, 3'd0, 1'b0, SR, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) period(1'b0, 1'b0, SR, 1'b0, 1'b0, 1'b0, 32'(k));
        add(1'b0, 3'd1, 1'b0, SD, 1'b1, 1'b0, 32'd4);
        add(1'b0, 3'd0, 1'b0, SI, 1'b1, 1'b0, 32'd4);

        // Stop during ARM.
        cur_ho = 16'd5;
        add(1'b1, 3'd0, 1'b0, SA, 1'b0, 1'b0, 32'd0);
        add(1'b1, 3'd0, 1'b0, SA, 1'b0, 1'b0, 32'd0);
        add(1'b0, 3'd0, 1'b0, SI, 1'b1, 1'b0, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].start, tbl[i].pc, tbl[i].ho, tbl[i].aoo, tbl[i].cid, tbl[i].ovl);
            step();
            check($sformatf("row%0d", i), actual_vec(),
                  expect_vec(tbl[i].st, tbl[i].ab, tbl[i].ovs, 1'b0, tbl[i].cnt));
        end

        // Asynchronous reset mid-RUN, off the clock edge.
        drive(1'b1, 32'd10, 16'd0, 1'b0, 3'd0, 1'b0);
        step();
        step();
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 32'd10, 16'd0, 1'b0, 3'(c % 5), 1'b0);
            step();
        end
        check("pre_reset_run", actual_vec(), expect_vec(SR, 1'b0, 1'b0, 1'b0, 32'd1));
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("async_reset_out", actual_vec(), expect_vec(SI, 1'b0, 1'b0, 1'b0, 32'd0));
        check("async_reset_sts", {32'd0, sts_data}, 64'd0);
        drive(1'b0, 32'd10, 16'd0, 1'b0, 3'd0, 1'b0);
        @(posedge aclk);
        #2 aresetn = 1'b1;
        step();
        check("post_reset_idle", actual_vec(), expect_vec(SI, 1'b0, 1'b0, 1'b0, 32'd0));
        drive(1'b1, 32'd10, 16'd0, 1'b0, 3'd0, 1'b0);
        step();
        check("clean_arm", actual_vec(), expect_vec(SA, 1'b0, 1'b0, 1'b0, 32'd0));
        step();
        check("clean_run", actual_vec(), expect_vec(SR, 1'b0, 1'b0, 1'b0, 32'd0));

        // Stuck core: case_id parked at 2 from RUN entry (RUN entered on the step above).
        drive(1'b1, 32'd10, 16'd0, 1'b0, 3'd2, 1'b0);
        repeat (63) step();
        check("wdog_63", actual_vec(), expect_vec(SR, 1'b0, 1'b0, 1'b0, 32'd0));
        step();
`ifdef PULSE_RUN_SEQUENCER_WATCHDOG_EN
        check("wdog_64", actual_vec(), expect_vec(SD, 1'b1, 1'b0, 1'b1, 32'd0));
`else
        check("wdog_64", actual_vec(), expect_vec(SR, 1'b0, 1'b0, 1'b0, 32'd0));
        repeat (40) step();
        check("no_wdog_104", actual_vec(), expect_vec(SR, 1'b0, 1'b0, 1'b0, 32'd0));
`endif
        drive(1'b0, 32'd10, 16'd0, 1'b0, 3'd0, 1'b0);
        step();
        step();
        check("final_idle", {61'd0, sts_data[31:29]}, {61'd0, SI});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
